multiport_register_file: RTL and testbench

Parametrised multi-port successor to the single-write, dual-read register file in the datapath. It provides `READ_PORTS` combinational read ports and two synchronous write ports, with configurable write-through bypass and an optional hard-wired zero register. A per-register busy scoreboard lets the issue stage detect operands still owed by an in-flight producer. The block sits between decode/issue and execute/writeback.

---
 rtl/multiport_register_file_pkg.sv | 13 +
 rtl/multiport_register_file_scoreboard.sv | 40 ++++
 rtl/multiport_register_file.sv | 88 ++++++++
 tb/tb_multiport_register_file.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multiport_register_file_pkg.sv
// Shared widths and types for the multi-port register file and its scoreboard.
// Combinational only; it adds no latency and has no backpressure.
package definitions;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_WIDTH      = 5;
  localparam int RF_READ_PORTS  = 2;
  localparam int RF_WRITE_PORTS = 2;

  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REG_WIDTH-1:0]  reg_idx_t;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy bits: set by lock, cleared by writeback, priority reset > lock > clear.
// State visible one edge after lock/clear; no backpressure, every request is absorbed.
module register_scoreboard
  import definitions::*;
#(
  parameter int ADDR_W   = REG_WIDTH,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   lock,
  input  logic [ADDR_W-1:0]                      lock_dest,
  input  logic [RF_WRITE_PORTS-1:0]              clear,
  input  logic [RF_WRITE_PORTS-1:0][ADDR_W-1:0]  clear_dest,
  output logic [2**ADDR_W-1:0]                   busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Lock is applied after clears so a fresh producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < RF_WRITE_PORTS; p++) begin
      if (clear[p]) busy_d[clear_dest[p]] = 1'b0;
    end
    if (lock) busy_d[lock_dest] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// Register file with READ_PORTS combinational reads, two writes, optional bypass and zero register.
// Writes land in one edge, reads are 0-cycle; no backpressure, all ports accept every cycle.
module multiport_register_file
  import definitions::*;
#(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = REG_WIDTH,
  parameter int READ_PORTS = RF_READ_PORTS,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                                   _CLK,
  input  logic                                   _RST,
  input  logic [RF_WRITE_PORTS-1:0]              _regWrite,
  input  logic [RF_WRITE_PORTS-1:0][ADDR_W-1:0]  _regDest,
  input  logic [RF_WRITE_PORTS-1:0][DATA_W-1:0]  _writeVal,
  input  logic [READ_PORTS-1:0][ADDR_W-1:0]      _regSrc,
  output logic [READ_PORTS-1:0][DATA_W-1:0]      value,
  output logic [READ_PORTS-1:0]                  srcBusy,
  input  logic                                   _lock,
  input  logic [ADDR_W-1:0]                      _lockDest
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]         regs [DEPTH];
  logic [DEPTH-1:0]          busy;
  logic [RF_WRITE_PORTS-1:0] wr_en;

  // Writes aimed at the hard-wired zero register are dropped before storage, bypass and scoreboard.
  always_comb begin
    wr_en = _regWrite;
    for (int p = 0; p < RF_WRITE_PORTS; p++) begin
      if (ZERO_REG && (_regDest[p] == '0)) wr_en[p] = 1'b0;
    end
  end

  // Port 1 is written last so it wins a same-destination conflict.
  always_ff @(posedge _CLK) begin
    if (_RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < RF_WRITE_PORTS; p++) begin
        if (wr_en[p]) regs[_regDest[p]] <= _writeVal[p];
      end
    end
  end

  register_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (_CLK),
    .rst        (_RST),
    .lock       (_lock),
    .lock_dest  (_lockDest),
    .clear      (wr_en),
    .clear_dest (_regDest),
    .busy       (busy)
  );

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
    logic [DATA_W-1:0] rd_val;
    logic              rd_busy;

    // A bypass hit means the producer is retiring right now, so the operand is no longer owed.
    always_comb begin
      rd_val  = regs[_regSrc[k]];
      rd_busy = busy[_regSrc[k]];
      if (BYPASS) begin
        for (int p = 0; p < RF_WRITE_PORTS; p++) begin
          if (wr_en[p] && (_regDest[p] == _regSrc[k])) begin
            rd_val  = _writeVal[p];
            rd_busy = 1'b0;
          end
        end
      end
      if (ZERO_REG && (_regSrc[k] == '0)) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end
    end

    assign value[k]   = rd_val;
    assign srcBusy[k] = rd_busy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench: directed table, reset sweep and random traffic on bypass and non-bypass instances.
module tb_multiport_register_file;
  import definitions::*;

  localparam int RP    = 2;
  localparam int DEPTH = 2**REG_WIDTH;

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic [1:0]                            we;
  logic [1:0][REG_WIDTH-1:0]             dest;
  logic [1:0][DATA_WIDTH-1:0]            wval;
  logic [RP-1:0][REG_WIDTH-1:0]          src;
  logic                                  lock;
  reg_idx_t                              ld;
  logic [RP-1:0][DATA_WIDTH-1:0]         val_b, val_n;
  logic [RP-1:0]                         busy_b, busy_n;

  always #5 clk = ~clk;

  multiport_register_file #(.READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    ._CLK(clk), ._RST(rst), ._regWrite(we), ._regDest(dest), ._writeVal(wval),
    ._regSrc(src), .value(val_b), .srcBusy(busy_b), ._lock(lock), ._lockDest(ld));

  multiport_register_file #(.READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    ._CLK(clk), ._RST(rst), ._regWrite(we), ._regDest(dest), ._writeVal(wval),
    ._regSrc(src), .value(val_n), .srcBusy(busy_n), ._lock(lock), ._lockDest(ld));

  int checks = 0;
  int fails  = 0;

  // Reference state: architectural contents and outstanding-producer flags.
  reg_data_t mem [DEPTH];
  bit        bsy [DEPTH];

  function automatic reg_data_t exp_val(reg_idx_t s, bit byp);
    reg_data_t v;
    if (s == 0) return '0;
    v = mem[s];
    if (byp) for (int p = 0; p < 2; p++) if (we[p] && dest[p] == s) v = wval[p];
    return v;
  endfunction

  function automatic bit exp_busy(reg_idx_t s, bit byp);
    if (s == 0) return 1'b0;
    if (byp) for (int p = 0; p < 2; p++) if (we[p] && dest[p] == s) return 1'b0;
    return bsy[s];
  endfunction

  task automatic commit();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; bsy[i] = 1'b0; end
    end else begin
      for (int p = 0; p < 2; p++) if (we[p] && dest[p] != 0) begin
        mem[dest[p]] = wval[p];
        bsy[dest[p]] = 1'b0;
      end
      if (lock && ld != 0) bsy[ld] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_model(string tag);
    for (int k = 0; k < RP; k++) begin
      check({tag, "_val_byp"},  val_b[k],  exp_val(src[k], 1'b1));
      check({tag, "_busy_byp"}, {31'b0, busy_b[k]}, {31'b0, exp_busy(src[k], 1'b1)});
      check({tag, "_val_nob"},  val_n[k],  exp_val(src[k], 1'b0));
      check({tag, "_busy_nob"}, {31'b0, busy_n[k]}, {31'b0, exp_busy(src[k], 1'b0)});
    end
  endtask

  task automatic idle();
    rst = 1'b0; we = 2'b00; lock = 1'b0;
  endtask

  typedef struct {
    logic [1:0] we;
    reg_idx_t   d0; reg_data_t w0;
    reg_idx_t   d1; reg_data_t w1;
    logic       lk; reg_idx_t  ld;
    reg_idx_t   s;
    reg_data_t  ev_b, ev_n;
    logic       eb_b, eb_n;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [1:0] w, int d0, int w0, int d1, int w1, logic lk, int l,
                     int s, int evb, int evn, logic ebb, logic ebn);
    vec_t v;
    v.we = w;
    v.d0 = reg_idx_t'(d0); v.w0 = reg_data_t'(w0);
    v.d1 = reg_idx_t'(d1); v.w1 = reg_data_t'(w1);
    v.lk = lk; v.ld = reg_idx_t'(l); v.s = reg_idx_t'(s);
    v.ev_b = reg_data_t'(evb); v.ev_n = reg_data_t'(evn);
    v.eb_b = ebb; v.eb_n = ebn;
    tbl.push_back(v);
  endtask

  initial begin
    idle();
    dest = '0; wval = '0; src = '0; ld = '0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; bsy[i] = 1'b0; end

    //   we     d0 w0  d1 w1  lk   ld s  ev_b ev_n eb_b eb_n
    add(2'b01, 2, 7,  0, 0,  1'b0, 0, 2, 7,  0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 2, 7,  7,  1'b0, 1'b0);
    add(2'b11, 5, 11, 5, 55, 1'b0, 0, 5, 55, 0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 5, 55, 55, 1'b0, 1'b0);
    add(2'b01, 0, 10, 0, 0,  1'b1, 0, 0, 0,  0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 0, 0,  0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b1, 3, 3, 0,  0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 3, 0,  0,  1'b1, 1'b1);
    add(2'b10, 0, 0,  3, 9,  1'b0, 0, 3, 9,  0,  1'b0, 1'b1);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 3, 9,  9,  1'b0, 1'b0);
    add(2'b01, 3, 14, 0, 0,  1'b1, 3, 3, 14, 9,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 3, 14, 14, 1'b1, 1'b1);
    add(2'b00, 2, 14, 0, 0,  1'b0, 0, 2, 7,  7,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 2, 7,  7,  1'b0, 1'b0);
    add(2'b01, 7, 3,  0, 0,  1'b1, 6, 7, 3,  0,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 7, 3,  3,  1'b0, 1'b0);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 6, 0,  0,  1'b1, 1'b1);
    add(2'b00, 6, 14, 0, 0,  1'b0, 0, 6, 0,  0,  1'b1, 1'b1);
    add(2'b00, 0, 0,  0, 0,  1'b0, 0, 6, 0,  0,  1'b1, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    tick();
    idle();
    src[0] = reg_idx_t'(9); src[1] = reg_idx_t'(31);
    #4;
    for (int k = 0; k < RP; k++) begin
      check("reset_val",  val_b[k], 32'd0);
      check("reset_busy", {31'b0, busy_b[k]}, 32'd0);
    end

    foreach (tbl[i]) begin
      we = tbl[i].we; lock = tbl[i].lk; ld = tbl[i].ld;
      dest[0] = tbl[i].d0; dest[1] = tbl[i].d1;
      wval[0] = tbl[i].w0; wval[1] = tbl[i].w1;
      src[0] = tbl[i].s; src[1] = tbl[i].s;
      #4;
      for (int k = 0; k < RP; k++) begin
        check($sformatf("vec%0d_val_byp", i),  val_b[k], tbl[i].ev_b);
        check($sformatf("vec%0d_val_nob", i),  val_n[k], tbl[i].ev_n);
        check($sformatf("vec%0d_busy_byp", i), {31'b0, busy_b[k]}, {31'b0, tbl[i].eb_b});
        check($sformatf("vec%0d_busy_nob", i), {31'b0, busy_n[k]}, {31'b0, tbl[i].eb_n});
      end
      tick();
    end

    // Reset sweep: fill with 0xFF and leave producers outstanding, then reset with colliding writes and a lock.
    idle();
    for (int r = 0; r < DEPTH; r += 2) begin
      we = 2'b11; dest[0] = reg_idx_t'(r); dest[1] = reg_idx_t'(r + 1);
      wval[0] = 32'hFF; wval[1] = 32'hFF;
      lock = 1'b1; ld = reg_idx_t'((r + 9) % DEPTH);
      tick();
    end
    rst = 1'b1; we = 2'b11; dest[0] = reg_idx_t'(4); dest[1] = reg_idx_t'(8);
    lock = 1'b1; ld = reg_idx_t'(12);
    tick();
    idle();
    for (int r = 0; r < DEPTH; r++) begin
      src[0] = reg_idx_t'(r); src[1] = reg_idx_t'(DEPTH - 1 - r);
      #1;
      check($sformatf("sweep%0d_val_byp", r),  val_b[0], 32'd0);
      check($sformatf("sweep%0d_val_nob", r),  val_n[1], 32'd0);
      check($sformatf("sweep%0d_busy_byp", r), {31'b0, busy_b[0]}, 32'd0);
      check($sformatf("sweep%0d_busy_nob", r), {31'b0, busy_n[1]}, 32'd0);
    end
    tick();

    // Random traffic over a small index range to provoke collisions, with occasional resets.
    for (int c = 0; c < 800; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      we   = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        dest[p] = reg_idx_t'($urandom_range(0, 7));
        wval[p] = $urandom;
      end
      lock = ($urandom_range(0, 2) == 0);
      ld   = reg_idx_t'($urandom_range(0, 7));
      for (int k = 0; k < RP; k++) src[k] = reg_idx_t'($urandom_range(0, 8));
      #4;
      check_model("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
